seq_detect_prog: RTL and testbench

//  Parametrised successor of the two-symbol A-then-B detector FSM.

---
 rtl/seq_detect_prog.sv | 209 ++++++++++++++++++++
 tb/tb_seq_detect_prog.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Programmable sequence detector with write-protected pattern slots, overlap mode and a saturating match counter.
// Optional inter-symbol timeout is enabled by defining SEQ_DET_TIMEOUT_EN.
module seq_detect_prog #(
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TO_CYC  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         cfg_we,
  input  logic [$clog2(MAX_LEN)-1:0]   cfg_addr,
  input  logic [SYM_W-1:0]             cfg_sym,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         in_valid,
  input  logic [SYM_W-1:0]             in_sym,
  input  logic                         cnt_clr,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [$clog2(MAX_LEN+1)-1:0] idx,
  output logic                         cfg_err
`ifdef SEQ_DET_TIMEOUT_EN
  ,
  output logic                         timeout
`endif
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN+1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  logic [SYM_W-1:0] pat_r [MAX_LEN];
  logic [LW-1:0]    len_r;
  logic             overlap_r;
  logic             cfg_err_r;
  state_t           state_r, state_s;
  logic [LW-1:0]    idx_r, idx_s;
  logic             match_r, match_s;
  logic [CNT_W-1:0] cnt_r;
  logic             addr_ok_s, len_ok_s;
  logic [SYM_W-1:0] exp_sym_s;
  logic             hit_s, first_s, last_s;

  if (SYM_W < 1 || MAX_LEN < 2 || CNT_W < 1 || TO_CYC < 1) begin : g_bad_param
    $error("seq_detect_prog: illegal parameter value");
  end

  // Range checks only exist when the port can encode an out-of-range value.
  if ((1 << AW) > MAX_LEN) begin : g_addr_chk
    assign addr_ok_s = (cfg_addr < AW'(MAX_LEN));
  end else begin : g_addr_full
    assign addr_ok_s = 1'b1;
  end

  if (((1 << LW) - 1) > MAX_LEN) begin : g_len_chk
    assign len_ok_s = (cfg_len <= LW'(MAX_LEN));
  end else begin : g_len_full
    assign len_ok_s = 1'b1;
  end

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC+1);
  logic [TW-1:0] to_cnt_r, to_cnt_s;
  logic          timeout_r, timeout_s;
`endif

  // Pattern registers; writes are refused while detection is enabled or the request is out of range.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) pat_r[i] <= {SYM_W{1'b0}};
      len_r     <= LW'(0);
      overlap_r <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= 1'b0;
      if (cfg_we) begin
        if (en || !addr_ok_s || !len_ok_s) begin
          cfg_err_r <= 1'b1;
        end else begin
          pat_r[cfg_addr] <= cfg_sym;
          len_r           <= cfg_len;
          overlap_r       <= cfg_overlap;
        end
      end
    end
  end

  // Symbol expected next: TRACK implies idx_r is nonzero and below len_r.
  always_comb begin
    exp_sym_s = pat_r[0];
    case (state_r)
      ST_TRACK:         exp_sym_s = pat_r[idx_r[AW-1:0]];
      ST_IDLE, ST_HUNT: exp_sym_s = pat_r[0];
      default:          exp_sym_s = pat_r[0];
    endcase
  end

  assign hit_s   = (in_sym == exp_sym_s);
  assign first_s = (in_sym == pat_r[0]);
  assign last_s  = ((idx_r + LW'(1)) == len_r);

  // Next-state, progress index and match pulse.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    match_s = 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
    to_cnt_s  = {TW{1'b0}};
    timeout_s = 1'b0;
`endif
    if (!en || len_r == LW'(0)) begin
      state_s = ST_IDLE;
      idx_s   = LW'(0);
    end else begin
      if (in_valid) begin
        if (hit_s) begin
          if (last_s) begin
            match_s = 1'b1;
            if (overlap_r && len_r > LW'(1) && first_s) begin
              idx_s = LW'(1);
            end else begin
              idx_s = LW'(0);
            end
          end else begin
            idx_s = idx_r + LW'(1);
          end
        end else begin
          // Single-symbol restart only: the failing symbol may begin a new attempt.
          if (first_s) begin
            idx_s = LW'(1);
          end else begin
            idx_s = LW'(0);
          end
        end
      end else begin
`ifdef SEQ_DET_TIMEOUT_EN
        if (state_r == ST_TRACK) begin
          if (to_cnt_r == TW'(TO_CYC - 1)) begin
            idx_s     = LW'(0);
            timeout_s = 1'b1;
          end else begin
            to_cnt_s = to_cnt_r + TW'(1);
          end
        end else begin
          to_cnt_s = {TW{1'b0}};
        end
`else
        idx_s = idx_r;
`endif
      end
      if (idx_s == LW'(0)) begin
        state_s = ST_HUNT;
      end else begin
        state_s = ST_TRACK;
      end
    end
  end

  // Detector state and registered pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      idx_r   <= LW'(0);
      match_r <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      match_r <= match_s;
    end
  end

  // Saturating match counter; clear has priority over a coincident match.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (match_s && cnt_r != {CNT_W{1'b1}}) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

`ifdef SEQ_DET_TIMEOUT_EN
  // Idle-gap counter and timeout pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      to_cnt_r  <= {TW{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      to_cnt_r  <= to_cnt_s;
      timeout_r <= timeout_s;
    end
  end
  assign timeout = timeout_r;
`endif

  assign match     = match_r;
  assign match_cnt = cnt_r;
  assign idx       = idx_r;
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog (SYM_W=4, MAX_LEN=4, CNT_W=2): a reference model pushes
// expected outputs per driven cycle; they are popped and compared one edge later.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [3:0] cfg_sym = 4'd0;
  logic [2:0] cfg_len = 3'd0;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_sym = 4'd0;
  logic       cnt_clr = 1'b0;
  logic       match;
  logic [1:0] match_cnt;
  logic [2:0] idx;
  logic       cfg_err;
`ifdef SEQ_DET_TIMEOUT_EN
  logic       timeout;
`endif

  seq_detect_prog #(.SYM_W(4), .MAX_LEN(4), .CNT_W(2), .TO_CYC(16)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_sym(cfg_sym), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .in_sym(in_sym), .cnt_clr(cnt_clr),
    .match(match), .match_cnt(match_cnt), .idx(idx), .cfg_err(cfg_err)
`ifdef SEQ_DET_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       m;
    logic [2:0] idx;
    logic [1:0] cnt;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [3:0] m_pat [4];
  int         m_len = 0;
  int         m_idx = 0;
  int         m_cnt = 0;
  bit         m_ov = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge given the currently driven inputs.
  task automatic model_step(output exp_t e);
    int nidx;
    bit nm;
    bit nerr;
    nm = 1'b0;
    nerr = 1'b0;
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_pat[i] = 4'd0;
      m_len = 0; m_ov = 1'b0; m_idx = 0; m_cnt = 0;
    end else begin
      nidx = m_idx;
      if (!en || m_len == 0) begin
        nidx = 0;
      end else if (in_valid) begin
        if (in_sym == m_pat[m_idx]) begin
          if (m_idx + 1 == m_len) begin
            nm = 1'b1;
            nidx = (m_ov && m_len > 1 && in_sym == m_pat[0]) ? 1 : 0;
          end else begin
            nidx = m_idx + 1;
          end
        end else begin
          nidx = (in_sym == m_pat[0]) ? 1 : 0;
        end
      end
      if (cnt_clr) m_cnt = 0;
      else if (nm && m_cnt < 3) m_cnt++;
      if (cfg_we) begin
        if (en || cfg_len > 3'd4) begin
          nerr = 1'b1;
        end else begin
          m_pat[cfg_addr] = cfg_sym;
          m_len = int'(cfg_len);
          m_ov = cfg_overlap;
        end
      end
      m_idx = nidx;
    end
    e.m = nm;
    e.idx = 3'(m_idx);
    e.cnt = 2'(m_cnt);
    e.err = nerr;
  endtask

  task automatic tick();
    exp_t e;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb_match", match, e.m);
    check("sb_idx", idx, e.idx);
    check("sb_cnt", match_cnt, e.cnt);
    check("sb_cfg_err", cfg_err, e.err);
  endtask

  task automatic drive(input bit e, input bit v, input logic [3:0] s, input bit clr);
    en = e; in_valid = v; in_sym = s; cnt_clr = clr; cfg_we = 1'b0;
    tick();
  endtask

  task automatic cfg(input logic [1:0] a, input logic [3:0] s, input logic [2:0] l, input bit ov);
    en = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    cfg_we = 1'b1; cfg_addr = a; cfg_sym = s; cfg_len = l; cfg_overlap = ov;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ovs [5];
    logic [3:0] syms [4];
    ovs = '{4'd3, 4'd5, 4'd3, 4'd5, 4'd3};
    syms = '{4'd3, 4'd5, 4'd7, 4'd1};

    reset = 1'b0;
    tick();
    tick();
    check("rst_match", match, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_idx", idx, 0);
    check("rst_cfg_err", cfg_err, 0);
    reset = 1'b1;

    // Writes refused: while enabled, and with an oversize length.
    en = 1'b1; in_valid = 1'b0; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_sym = 4'd3;
    cfg_len = 3'd1; cfg_overlap = 1'b0;
    tick();
    cfg_we = 1'b0;
    check("err_en", cfg_err, 1);
    drive(1'b1, 1'b1, 4'd3, 1'b0);
    check("err_en_unchanged", match, 0);
    check("err_pulse_len", cfg_err, 0);
    cfg(2'd0, 4'd3, 3'd5, 1'b0);
    check("err_len", cfg_err, 1);

    // Pattern 3,5,7.
    cfg(2'd0, 4'd3, 3'd3, 1'b0);
    cfg(2'd1, 4'd5, 3'd3, 1'b0);
    cfg(2'd2, 4'd7, 3'd3, 1'b0);
    drive(1'b1, 1'b1, 4'd3, 1'b0); check("idx_1", idx, 1);
    drive(1'b1, 1'b1, 4'd5, 1'b0); check("idx_2", idx, 2);
    drive(1'b1, 1'b1, 4'd7, 1'b0); check("match_357", match, 1);
    check("idx_wrap", idx, 0); check("cnt_1", match_cnt, 1);
    drive(1'b1, 1'b0, 4'd0, 1'b0); check("match_one_cycle", match, 0);

    // Mismatch restart.
    drive(1'b1, 1'b1, 4'd3, 1'b0);
    drive(1'b1, 1'b1, 4'd3, 1'b0); check("idx_restart", idx, 1);
    drive(1'b1, 1'b1, 4'd5, 1'b0);
    drive(1'b1, 1'b1, 4'd7, 1'b0); check("match_restart", match, 1);
    check("cnt_2", match_cnt, 2);

    // Gaps inside the stream.
    drive(1'b0, 1'b0, 4'd0, 1'b1); check("cnt_clr", match_cnt, 0);
    drive(1'b1, 1'b1, 4'd3, 1'b0);
    drive(1'b1, 1'b0, 4'd9, 1'b0);
    drive(1'b1, 1'b0, 4'd9, 1'b0); check("idx_hold_gap", idx, 1);
    drive(1'b1, 1'b1, 4'd5, 1'b0);
    drive(1'b1, 1'b0, 4'd7, 1'b0); check("idx_hold_gap2", idx, 2);
    drive(1'b1, 1'b1, 4'd7, 1'b0); check("match_gaps", match, 1);
    check("cnt_gaps", match_cnt, 1);

    // Pattern 3,5,3 with and without overlap.
    cfg(2'd2, 4'd3, 3'd3, 1'b1);
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, ovs[i], 1'b0);
    check("overlap_on_cnt", match_cnt, 2);
    cfg(2'd2, 4'd3, 3'd3, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, ovs[i], 1'b0);
    check("overlap_off_cnt", match_cnt, 1);

    // Length 1: back-to-back pulses, saturation, clear beats increment.
    cfg(2'd0, 4'd3, 3'd1, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 4'd3, 1'b0);
      check("b2b_match", match, 1);
      check("len1_idx", idx, 0);
    end
    check("cnt_sat", match_cnt, 3);
    drive(1'b1, 1'b1, 4'd3, 1'b1);
    check("clr_match", match, 1);
    check("clr_wins", match_cnt, 0);

    // Enable dropped with idx=2.
    cfg(2'd0, 4'd3, 3'd3, 1'b0);
    cfg(2'd2, 4'd7, 3'd3, 1'b0);
    drive(1'b1, 1'b1, 4'd3, 1'b0);
    drive(1'b1, 1'b1, 4'd5, 1'b0); check("idx_pre_drop", idx, 2);
    drive(1'b0, 1'b1, 4'd7, 1'b0);
    check("drop_idx", idx, 0); check("drop_match", match, 0);
    drive(1'b1, 1'b1, 4'd7, 1'b0); check("drop_no_resume", match, 0);

    // Random streams on two configurations.
    for (int k = 0; k < 2; k++) begin
      if (k == 1) cfg(2'd2, 4'd3, 3'd3, 1'b1);
      for (int i = 0; i < 300; i++) begin
        drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
              syms[$urandom_range(0, 3)], ($urandom_range(0, 19) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
